// File: rtl/ruler_search_controller_pkg.sv
// Shared types and helpers for the Golomb-ruler search controller.
package ruler_pkg;
  localparam int VAL_W   = 9;
  localparam int LEVEL_W = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_COMMIT,
    S_DONE
  } state_t;

  function automatic int marks_w(input int n);
    return (n + 1) * VAL_W;
  endfunction

  // The leaf mark sits in the least-significant field of the marks bus.
  function automatic logic [VAL_W-1:0] leaf_mark(input logic [VAL_W-1:0] lsb_field);
    return lsb_field;
  endfunction
endpackage

// File: rtl/ruler_search_controller_if.sv
// Controller <-> mark-counter chain bundle.
// Handshake: step is a one-cycle request; counter_ready may be held or pulsed and is
// only honoured from the cycle after step; next_enabled/success/marks_in are valid with it.
interface ruler_search_controller_if import ruler_pkg::*; #(
  parameter int NUMPOSITIONS = 5
);
  logic [LEVEL_W-1:0]               enabled;
  logic [VAL_W-1:0]                 limit;
  logic                             counters_clear;
  logic                             step;
  logic                             counter_ready;
  logic [LEVEL_W-1:0]               next_enabled;
  logic                             success;
  logic [marks_w(NUMPOSITIONS)-1:0] marks_in;

  modport master (
    output enabled, limit, counters_clear, step,
    input  counter_ready, next_enabled, success, marks_in
  );

  modport slave (
    input  enabled, limit, counters_clear, step,
    output counter_ready, next_enabled, success, marks_in
  );
endinterface

// File: rtl/ruler_search_controller_best_ruler_store.sv
// Best-ruler register: latches the winning ruler, counts successes and tightens the limit.
module best_ruler_store import ruler_pkg::*; #(
  parameter int NUMPOSITIONS = 5
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clear_i,
  input  logic [VAL_W-1:0]                 init_limit_i,
  input  logic                             commit_i,
  input  logic [marks_w(NUMPOSITIONS)-1:0] marks_i,
  output logic [VAL_W-1:0]                 limit_o,
  output logic [marks_w(NUMPOSITIONS)-1:0] best_marks_o,
  output logic                             best_valid_o,
  output logic [15:0]                      found_count_o
);
  logic [VAL_W-1:0] leaf;
  assign leaf = leaf_mark(marks_i[VAL_W-1:0]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      limit_o       <= '0;
      best_marks_o  <= '0;
      best_valid_o  <= 1'b0;
      found_count_o <= '0;
    end else if (clear_i) begin
      limit_o       <= init_limit_i;
      best_valid_o  <= 1'b0;
      found_count_o <= '0;
    end else if (commit_i) begin
      // commit_i is only raised for a nonzero leaf, so this never wraps
      limit_o      <= leaf - 1'b1;
      best_marks_o <= marks_i;
      best_valid_o <= 1'b1;
      if (found_count_o != 16'hFFFF) found_count_o <= found_count_o + 16'd1;
    end
  end
endmodule

// File: rtl/ruler_search_controller.sv
// Top sequencer of the optimal-Golomb-ruler search. Optional step counter: RULER_STATS_EN.
module ruler_search_controller import ruler_pkg::*; #(
  parameter int NUMPOSITIONS = 5,
  parameter int MAXVALUE     = 500
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [VAL_W-1:0]                 initial_limit,
  ruler_search_controller_if.master        cif,
  output logic [marks_w(NUMPOSITIONS)-1:0] best_marks,
  output logic                             best_valid,
  output logic [15:0]                      found_count,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [31:0]                      step_count,
  output state_t                           dbg_state
);
  localparam int MW = marks_w(NUMPOSITIONS);

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] enabled_q, enabled_d;
  logic               error_q, error_d, busy_q, busy_d, done_q, done_d;
  logic               clear_q, clear_d, step_q, step_d;
  logic [LEVEL_W-1:0] cap_next_q;
  logic               cap_success_q;
  logic [MW-1:0]      cap_marks_q;
  logic               cap_en, accept, commit;
  logic [VAL_W-1:0]   leaf, new_limit, limit, init_clamped;
  logic               at_leaf, leaf_ok;

  assign leaf         = leaf_mark(cap_marks_q[VAL_W-1:0]);
  assign at_leaf      = (enabled_q == LEVEL_W'(NUMPOSITIONS));
  assign leaf_ok      = cap_success_q && at_leaf && (leaf != '0);
  assign new_limit    = leaf_ok ? (leaf - 1'b1) : limit;
  assign init_clamped = (initial_limit > VAL_W'(MAXVALUE)) ? VAL_W'(MAXVALUE) : initial_limit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      enabled_q     <= '0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      clear_q       <= 1'b0;
      step_q        <= 1'b0;
      cap_next_q    <= '0;
      cap_success_q <= 1'b0;
      cap_marks_q   <= '0;
    end else begin
      state_q   <= state_d;
      enabled_q <= enabled_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      clear_q   <= clear_d;
      step_q    <= step_d;
      if (cap_en) begin
        cap_next_q    <= cif.next_enabled;
        cap_success_q <= cif.success;
        cap_marks_q   <= cif.marks_in;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    enabled_d = enabled_q;
    error_d   = error_q;
    busy_d    = busy_q;
    done_d    = done_q;
    cap_en    = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          enabled_d = LEVEL_W'(1);
          error_d   = 1'b0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (cif.counter_ready) begin
          cap_en  = 1'b1;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        commit    = leaf_ok;
        enabled_d = cap_next_q;
        // a success reported above the leaf is a protocol fault, but the step still commits
        if (cap_success_q && !at_leaf) error_d = 1'b1;
        if (cap_next_q > LEVEL_W'(NUMPOSITIONS)) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else if (cap_next_q == '0 || new_limit == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
        if (state_d == S_DONE) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    clear_d = (state_d == S_CLEAR);
    step_d  = (state_d == S_ISSUE);
  end

  best_ruler_store #(.NUMPOSITIONS(NUMPOSITIONS)) u_store (
    .clock         (clock),
    .reset         (reset),
    .clear_i       (accept),
    .init_limit_i  (init_clamped),
    .commit_i      (commit),
    .marks_i       (cap_marks_q),
    .limit_o       (limit),
    .best_marks_o  (best_marks),
    .best_valid_o  (best_valid),
    .found_count_o (found_count)
  );

`ifdef RULER_STATS_EN
  logic [31:0] step_count_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      step_count_q <= '0;
    else if (accept) step_count_q <= '0;
    else if (step_q) step_count_q <= step_count_q + 32'd1;
  end
  assign step_count = step_count_q;
`else
  assign step_count = '0;
`endif

  assign cif.enabled        = enabled_q;
  assign cif.limit          = limit;
  assign cif.counters_clear = clear_q;
  assign cif.step           = step_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;
  assign dbg_state          = state_q;
endmodule
